// File: rtl/pipe_drain_pkg.sv
// Shared types and helpers for the pipeline drain controller.
// Holds the default result width and the modulo pointer helper.
package pipe_drain_pkg;

    localparam int DATA_W_DEF = 16;

    typedef logic [DATA_W_DEF-1:0] result_t;

    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_drain_ctrl_fifo.sv
// Small result FIFO with occupancy count for the drain controller.
// Head word is presented combinationally from storage.
module drain_fifo
    import pipe_drain_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DATA_W_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != CW'(DEPTH));
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (do_pop) begin
            rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pipe_drain_ctrl.sv
// Consumer-side controller for the two-stage stalled pipeline:
// valid shadow, stall generation, result capture and drain.
module pipe_drain_ctrl
    import pipe_drain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              stall,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mismatch,
    output logic [CNT_W-1:0]  captured
);

    localparam int CW = $clog2(DEPTH + 1);

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] captured_q, captured_d;
    logic [CW-1:0]    count;
    logic             empty;
    logic             push, pop;

    // Stall only looks at fullness and v2, never at out_ready.
    assign stall     = v2_q && (count == CW'(DEPTH));
    assign in_ready  = !stall;
    assign push      = v2_q && !stall;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign mismatch  = mismatch_q;
    assign captured  = captured_q;

    drain_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (d1),
        .rdata (out_data),
        .count (count),
        .empty (empty)
    );

    always_comb begin
        v1_d       = v1_q;
        v2_d       = v2_q;
        mismatch_d = mismatch_q;
        captured_d = captured_q;
        if (!stall) begin
            v1_d = in_valid;
            v2_d = v1_q;
        end
        if (push) begin
            captured_d = captured_q + CNT_W'(1);
            if (d1 != d2) begin
                mismatch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            mismatch_q <= 1'b0;
            captured_q <= '0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            mismatch_q <= mismatch_d;
            captured_q <= captured_d;
        end
    end

`ifdef FORMAL
    logic all_match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_match_q <= 1'b1;
        end else if (push && (d1 != d2)) begin
            all_match_q <= 1'b0;
        end
    end

    always_comb begin
        if (rst_n) begin
            a_count: assert (count <= CW'(DEPTH));
            a_nopush: assert (!(push && (count == CW'(DEPTH))));
            a_valid: assert (out_valid == (count != '0));
            a_stall: assert (!stall || v2_q);
            a_mism: assert (!all_match_q || !mismatch_q);
        end
    end
`endif

endmodule
